// File: rtl/ex_stage_pkg.sv
// Shared definitions for the RV32 execute stage: op codes, FSM states, decode helpers.
// The RV32M_EN macro (see ex_stage.sv) selects whether the M-extension codes are legal.
package ex_stage_pkg;

    localparam int XLEN     = 32;
    localparam int MD_ITERS = 32;

    localparam logic [4:0] EX_OP_ADD    = 5'd0;
    localparam logic [4:0] EX_OP_SUB    = 5'd1;
    localparam logic [4:0] EX_OP_SLL    = 5'd2;
    localparam logic [4:0] EX_OP_SLT    = 5'd3;
    localparam logic [4:0] EX_OP_SLTU   = 5'd4;
    localparam logic [4:0] EX_OP_XOR    = 5'd5;
    localparam logic [4:0] EX_OP_SRL    = 5'd6;
    localparam logic [4:0] EX_OP_SRA    = 5'd7;
    localparam logic [4:0] EX_OP_OR     = 5'd8;
    localparam logic [4:0] EX_OP_AND    = 5'd9;
    localparam logic [4:0] EX_OP_PASSB  = 5'd10;
    localparam logic [4:0] EX_OP_MUL    = 5'd16;
    localparam logic [4:0] EX_OP_MULH   = 5'd17;
    localparam logic [4:0] EX_OP_MULHSU = 5'd18;
    localparam logic [4:0] EX_OP_MULHU  = 5'd19;
    localparam logic [4:0] EX_OP_DIV    = 5'd20;
    localparam logic [4:0] EX_OP_DIVU   = 5'd21;
    localparam logic [4:0] EX_OP_REM    = 5'd22;
    localparam logic [4:0] EX_OP_REMU   = 5'd23;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } ex_state_t;

    function automatic logic ex_op_is_alu(input logic [4:0] op);
        return op <= EX_OP_PASSB;
    endfunction

    function automatic logic ex_op_is_md(input logic [4:0] op);
        return (op >= EX_OP_MUL) && (op <= EX_OP_REMU);
    endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative RV32M core: shift-add multiply and restoring divide on operand magnitudes,
// with sign correction applied combinationally to the final accumulator.
module ex_muldiv
    import ex_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            clear,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            last,
    output logic [XLEN-1:0] result
);

    logic        run;
    logic [4:0]  cnt;
    logic [63:0] acc;
    logic [31:0] opnd;
    logic        is_div, sel_hi, q_neg, r_neg;

    logic        a_signed, b_signed, a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum, rem_sh;
    logic [33:0] diff;
    logic [63:0] step_nxt, prod;
    logic [31:0] quo, rem;

    always_comb begin
        a_signed = (op == EX_OP_MULH) || (op == EX_OP_MULHSU) ||
                   (op == EX_OP_DIV)  || (op == EX_OP_REM);
        b_signed = (op == EX_OP_MULH) || (op == EX_OP_DIV) || (op == EX_OP_REM);
        a_neg    = a_signed && a[31];
        b_neg    = b_signed && b[31];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
    end

    // Multiply shifts the product right through acc; divide shifts dividend bits left into the remainder.
    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        rem_sh   = {acc[63:32], acc[31]};
        diff     = {1'b0, rem_sh} - {2'b00, opnd};
        step_nxt = {mul_sum, acc[31:1]};
        if (is_div) begin
            step_nxt = diff[33] ? {rem_sh[31:0], acc[30:0], 1'b0}
                                : {diff[31:0],   acc[30:0], 1'b1};
        end
    end

    always_comb begin
        prod   = q_neg ? -acc : acc;
        quo    = q_neg ? -acc[31:0] : acc[31:0];
        rem    = r_neg ? -acc[63:32] : acc[63:32];
        result = is_div ? (sel_hi ? rem : quo) : (sel_hi ? prod[63:32] : prod[31:0]);
    end

    assign last = run && (cnt == 5'(MD_ITERS - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            run <= 1'b0;
            cnt <= '0;
        end else if (start) begin
            run    <= 1'b1;
            cnt    <= '0;
            is_div <= op[2];
            sel_hi <= op[2] ? op[1] : (op[1:0] != 2'b00);
            // A zero divisor yields all-ones quotient regardless of dividend sign.
            q_neg  <= (a_neg ^ b_neg) && !(op[2] && (b == '0));
            r_neg  <= a_neg;
            opnd   <= op[2] ? b_mag : a_mag;
            acc    <= {32'd0, op[2] ? a_mag : b_mag};
        end else if (run) begin
            acc <= step_nxt;
            cnt <= cnt + 5'd1;
            if (last) begin
                run <= 1'b0;
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ex_stage.sv
// RV32 execute stage: single-cycle ALU plus, when RV32M_EN is defined, an iterative mul/div path.
// Handshake: an op transfers when ID_vld && EX_rdy && !ID_flush; results appear as a one-cycle EX_x_rd_vld.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            ID_vld,
    output logic            EX_rdy,
    input  logic            ID_flush,
    input  logic [4:0]      ID_alu_op,
    input  logic [4:0]      ID_rd,
    input  logic            ID_rd_wen,
    input  logic            ID_use_imm,
    input  logic [XLEN-1:0] ID_imm,
    input  logic [XLEN-1:0] OF_x_rs1,
    input  logic [XLEN-1:0] OF_x_rs2,
    output logic [4:0]      EX_rd,
    output logic [XLEN-1:0] EX_x_rd,
    output logic            EX_x_rd_vld,
    output logic            EX_busy,
    output logic            EX_illegal,
    output ex_state_t       dbg_state
);

    ex_state_t       state;
    logic            accept;
    logic            md_legal;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_res;

    assign accept = ID_vld && EX_rdy && !ID_flush;
    assign op_b   = ID_use_imm ? ID_imm : OF_x_rs2;
    assign EX_rdy = (state == ST_IDLE);
    assign dbg_state = state;

    always_comb begin
        alu_res = '0;
        case (ID_alu_op)
            EX_OP_ADD:   alu_res = OF_x_rs1 + op_b;
            EX_OP_SUB:   alu_res = OF_x_rs1 - op_b;
            EX_OP_SLL:   alu_res = OF_x_rs1 << op_b[4:0];
            EX_OP_SLT:   alu_res = {31'd0, $signed(OF_x_rs1) < $signed(op_b)};
            EX_OP_SLTU:  alu_res = {31'd0, OF_x_rs1 < op_b};
            EX_OP_XOR:   alu_res = OF_x_rs1 ^ op_b;
            EX_OP_SRL:   alu_res = OF_x_rs1 >> op_b[4:0];
            EX_OP_SRA:   alu_res = $unsigned($signed(OF_x_rs1) >>> op_b[4:0]);
            EX_OP_OR:    alu_res = OF_x_rs1 | op_b;
            EX_OP_AND:   alu_res = OF_x_rs1 & op_b;
            EX_OP_PASSB: alu_res = op_b;
            default:     alu_res = '0;
        endcase
    end

`ifdef RV32M_EN
    logic            md_start, md_last;
    logic [XLEN-1:0] md_result;
    logic [4:0]      md_rd;
    logic            md_wen;

    assign md_legal = ex_op_is_md(ID_alu_op);
    assign md_start = accept && md_legal;
    assign EX_busy  = (state != ST_IDLE);

    ex_muldiv u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .clear  (ID_flush),
        .op     (ID_alu_op),
        .a      (OF_x_rs1),
        .b      (op_b),
        .last   (md_last),
        .result (md_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            md_rd  <= '0;
            md_wen <= 1'b0;
        end else if (ID_flush) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (md_start) begin
                    state  <= ST_CALC;
                    md_rd  <= ID_rd;
                    md_wen <= ID_rd_wen;
                end
                ST_CALC: if (md_last) state <= ST_FIX;
                ST_FIX:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
`else
    assign md_legal = 1'b0;
    assign EX_busy  = 1'b0;
    assign state    = ST_IDLE;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            EX_rd       <= '0;
            EX_x_rd     <= '0;
            EX_x_rd_vld <= 1'b0;
            EX_illegal  <= 1'b0;
        end else begin
            EX_x_rd_vld <= 1'b0;
            EX_illegal  <= 1'b0;
            if (accept) begin
                if (ex_op_is_alu(ID_alu_op)) begin
                    EX_rd       <= ID_rd;
                    EX_x_rd     <= alu_res;
                    EX_x_rd_vld <= ID_rd_wen && (ID_rd != 5'd0);
                end else if (!md_legal) begin
                    EX_illegal <= 1'b1;
                end
            end
`ifdef RV32M_EN
            // FIX and IDLE are exclusive, so this never collides with an ALU writeback.
            if ((state == ST_FIX) && !ID_flush) begin
                EX_rd       <= md_rd;
                EX_x_rd     <= md_result;
                EX_x_rd_vld <= md_wen && (md_rd != 5'd0);
            end
`endif
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed vector table, hand-written flush/back-to-back/reset sequences,
// and random ops scored against an arithmetic reference model. Honours RV32M_EN like the RTL.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ID_vld, ID_flush, ID_rd_wen, ID_use_imm;
    logic [4:0]  ID_alu_op, ID_rd;
    logic [31:0] ID_imm, OF_x_rs1, OF_x_rs2;
    logic        EX_rdy, EX_x_rd_vld, EX_busy, EX_illegal;
    logic [4:0]  EX_rd;
    logic [31:0] EX_x_rd;
    ex_state_t   dbg_state;

    int n_vec = 0;
    int n_err = 0;
    logic [36:0] exp_q[$];

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [4:0]  rd;
        logic        wen;
        logic        use_imm;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl[$];

    ex_stage dut (
        .clk         (clk),
        .rst         (rst),
        .ID_vld      (ID_vld),
        .EX_rdy      (EX_rdy),
        .ID_flush    (ID_flush),
        .ID_alu_op   (ID_alu_op),
        .ID_rd       (ID_rd),
        .ID_rd_wen   (ID_rd_wen),
        .ID_use_imm  (ID_use_imm),
        .ID_imm      (ID_imm),
        .OF_x_rs1    (OF_x_rs1),
        .OF_x_rs2    (OF_x_rs2),
        .EX_rd       (EX_rd),
        .EX_x_rd     (EX_x_rd),
        .EX_x_rd_vld (EX_x_rd_vld),
        .EX_busy     (EX_busy),
        .EX_illegal  (EX_illegal),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endfunction

    // Reference: results from plain integer arithmetic; lat 0 means the op must be rejected as illegal.
    function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output int lat, output logic [31:0] r);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      ua = longint'({32'd0, a});
        longint      ub = longint'({32'd0, b});
        logic [63:0] p;
        lat = 1;
        r   = '0;
        p   = '0;
        case (op)
            EX_OP_ADD:   r = a + b;
            EX_OP_SUB:   r = a - b;
            EX_OP_SLL:   r = a << b[4:0];
            EX_OP_SLT:   r = {31'd0, sa < sb};
            EX_OP_SLTU:  r = {31'd0, ua < ub};
            EX_OP_XOR:   r = a ^ b;
            EX_OP_SRL:   r = a >> b[4:0];
            EX_OP_SRA:   r = 32'(sa >>> b[4:0]);
            EX_OP_OR:    r = a | b;
            EX_OP_AND:   r = a & b;
            EX_OP_PASSB: r = b;
`ifdef RV32M_EN
            EX_OP_MUL:    begin lat = 34; p = 64'(ua * ub); r = p[31:0];  end
            EX_OP_MULH:   begin lat = 34; p = 64'(sa * sb); r = p[63:32]; end
            EX_OP_MULHSU: begin lat = 34; p = 64'(sa * ub); r = p[63:32]; end
            EX_OP_MULHU:  begin lat = 34; p = 64'(ua * ub); r = p[63:32]; end
            EX_OP_DIV:    begin lat = 34; r = (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb); end
            EX_OP_DIVU:   begin lat = 34; r = (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub); end
            EX_OP_REM:    begin lat = 34; r = (b == 0) ? a : 32'(sa % sb); end
            EX_OP_REMU:   begin lat = 34; r = (b == 0) ? a : 32'(ua % ub); end
`endif
            default: lat = 0;
        endcase
    endfunction

    task automatic drive(input logic [4:0] op, input logic [4:0] rd, input logic wen, input logic use_imm,
                         input logic [31:0] imm, input logic [31:0] rs1, input logic [31:0] rs2);
        ID_alu_op  = op;
        ID_rd      = rd;
        ID_rd_wen  = wen;
        ID_use_imm = use_imm;
        ID_imm     = imm;
        OF_x_rs1   = rs1;
        OF_x_rs2   = rs2;
        ID_vld     = 1'b1;
    endtask

    task automatic wait_rdy(input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (!EX_rdy && k < 60) begin
            @(negedge clk);
            k++;
        end
        check({name, "_rdy_wait"}, {31'd0, EX_rdy}, 32'd1);
    endtask

    task automatic run_op(input vec_t v);
        int vld_at, ill_at, stall_bad, window;
        logic [31:0] got_val;
        logic [4:0]  got_rd;
        wait_rdy(v.name);
        drive(v.op, v.rd, v.wen, v.use_imm, v.imm, v.rs1, v.rs2);
        @(posedge clk); #1;
        ID_vld = 1'b0;
        vld_at = -1; ill_at = -1; stall_bad = 0;
        got_val = '0; got_rd = '0;
        window = (v.lat == 0) ? 3 : v.lat + 1;
        for (int k = 1; k <= window; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            if (EX_x_rd_vld && vld_at < 0) vld_at = k;
            if (EX_illegal && ill_at < 0) ill_at = k;
            if (k < v.lat && (EX_rdy !== 1'b0 || EX_busy !== 1'b1)) stall_bad++;
            if (k == v.lat) begin
                got_val = EX_x_rd;
                got_rd  = EX_rd;
                if (v.lat > 1) begin
                    check({v.name, "_rdy_at_done"}, {31'd0, EX_rdy}, 32'd1);
                    check({v.name, "_busy_at_done"}, {31'd0, EX_busy}, 32'd0);
                end
            end
        end
        check({v.name, "_vld_cycle"}, vld_at, (v.lat > 0 && v.wen && v.rd != 0) ? v.lat : -1);
        check({v.name, "_illegal_cycle"}, ill_at, (v.lat == 0) ? 1 : -1);
        if (v.lat > 0) begin
            check({v.name, "_value"}, got_val, v.exp);
            check({v.name, "_rd"}, {27'd0, got_rd}, {27'd0, v.rd});
        end
        if (v.lat > 1) check({v.name, "_stall_cycles_bad"}, stall_bad, 0);
    endtask

    function automatic void add(input string name, input logic [4:0] op, input logic [4:0] rd,
                                input logic wen, input logic use_imm, input logic [31:0] imm,
                                input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [31:0] exp, input int lat);
        vec_t v;
        v.name = name; v.op = op; v.rd = rd; v.wen = wen; v.use_imm = use_imm;
        v.imm = imm; v.rs1 = rs1; v.rs2 = rs2; v.exp = exp; v.lat = lat;
        tbl.push_back(v);
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'd0;
            3: return 32'(32'($urandom_range(0, 40)));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int vcount, lat;
        logic [31:0] val, rs1, rs2, imm, b;
        logic [4:0]  op, rd;
        logic        wen, use_imm;
        logic [36:0] got_e;

        rst = 1'b1; ID_vld = 1'b0; ID_flush = 1'b0;
        drive(EX_OP_ADD, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        ID_vld = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_rdy", {31'd0, EX_rdy}, 32'd1);
        check("reset_rd", {27'd0, EX_rd}, 32'd0);
        check("reset_x_rd", EX_x_rd, 32'd0);
        check("reset_vld", {31'd0, EX_x_rd_vld}, 32'd0);
        check("reset_busy", {31'd0, EX_busy}, 32'd0);
        check("reset_illegal", {31'd0, EX_illegal}, 32'd0);
        check("reset_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});

        add("add_imm",   EX_OP_ADD,   5'd3,  1, 1, 32'hFFFF_FFF9, 32'd5,        32'd0,        32'hFFFF_FFFE, 1);
        add("sra",       EX_OP_SRA,   5'd7,  1, 0, 32'd0,         32'h8000_0000, 32'd33,      32'hC000_0000, 1);
        add("sltu",      EX_OP_SLTU,  5'd8,  1, 0, 32'd0,         32'd1,        32'hFFFF_FFFF, 32'd1,        1);
        add("add_x0",    EX_OP_ADD,   5'd0,  1, 0, 32'd0,         32'd1,        32'd2,        32'd3,         1);
        add("add_nowen", EX_OP_ADD,   5'd5,  0, 0, 32'd0,         32'd10,       32'd20,       32'd30,        1);
        add("sub",       EX_OP_SUB,   5'd9,  1, 0, 32'd0,         32'd3,        32'd5,        32'hFFFF_FFFE, 1);
        add("sll",       EX_OP_SLL,   5'd10, 1, 0, 32'd0,         32'd1,        32'd31,       32'h8000_0000, 1);
        add("slt",       EX_OP_SLT,   5'd11, 1, 0, 32'd0,         32'hFFFF_FFFF, 32'd1,       32'd1,         1);
        add("sltu_big",  EX_OP_SLTU,  5'd12, 1, 0, 32'd0,         32'hFFFF_FFFF, 32'd1,       32'd0,         1);
        add("xor",       EX_OP_XOR,   5'd13, 1, 0, 32'd0,         32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1);
        add("srl",       EX_OP_SRL,   5'd14, 1, 0, 32'd0,         32'h8000_0000, 32'd4,       32'h0800_0000, 1);
        add("or",        EX_OP_OR,    5'd15, 1, 0, 32'd0,         32'h0F0,      32'h00F,      32'h0FF,       1);
        add("and",       EX_OP_AND,   5'd16, 1, 0, 32'd0,         32'hFF00,     32'h0FF0,     32'h0F00,      1);
        add("passb",     EX_OP_PASSB, 5'd17, 1, 1, 32'h1234_5000, 32'hDEAD_BEEF, 32'd0,       32'h1234_5000, 1);
        add("bad_op",    5'd11,       5'd18, 1, 0, 32'd0,         32'd1,        32'd1,        32'd0,         0);
`ifdef RV32M_EN
        add("mulh",   EX_OP_MULH,   5'd1, 1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         34);
        add("mulhu",  EX_OP_MULHU,  5'd2, 1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        add("mul",    EX_OP_MUL,    5'd3, 1, 0, 0, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFA, 34);
        add("mulhsu", EX_OP_MULHSU, 5'd4, 1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
        add("div_0",  EX_OP_DIV,    5'd5, 1, 0, 0, 32'd7,         32'd0,         32'hFFFF_FFFF, 34);
        add("rem_0",  EX_OP_REM,    5'd6, 1, 0, 0, 32'd7,         32'd0,         32'd7,         34);
        add("div_ov", EX_OP_DIV,    5'd7, 1, 0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);
        add("rem_ov", EX_OP_REM,    5'd8, 1, 0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         34);
        add("rem_neg", EX_OP_REM,   5'd9, 1, 0, 0, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
        add("div_neg", EX_OP_DIV,   5'd9, 1, 0, 0, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
        add("divu",   EX_OP_DIVU,   5'd10, 1, 0, 0, 32'd100,      32'd7,         32'd14,        34);
        add("remu",   EX_OP_REMU,   5'd11, 1, 0, 0, 32'd100,      32'd7,         32'd2,         34);
`else
        add("mul_illegal", EX_OP_MUL, 5'd1, 1, 0, 0, 32'd3, 32'd4, 32'd0, 0);
`endif
        foreach (tbl[i]) run_op(tbl[i]);

        // Flush together with a presented op: nothing is accepted.
        wait_rdy("flush_same");
        drive(EX_OP_ADD, 5'd4, 1'b1, 1'b0, 32'd0, 32'd1, 32'd1);
        ID_flush = 1'b1;
        @(posedge clk); #1;
        ID_vld = 1'b0; ID_flush = 1'b0;
        check("flush_same_vld", {31'd0, EX_x_rd_vld}, 32'd0);
        check("flush_same_rdy", {31'd0, EX_rdy}, 32'd1);

`ifdef RV32M_EN
        // Flush at T+10 of a DIVU; ADD accepted at T+11 must write back at T+12.
        wait_rdy("flush_md");
        drive(EX_OP_DIVU, 5'd6, 1'b1, 1'b0, 32'd0, 32'd100, 32'd7);
        @(posedge clk); #1;
        ID_vld = 1'b0;
        vcount = 0;
        for (int k = 1; k <= 9; k++) begin
            if (EX_x_rd_vld) vcount++;
            @(posedge clk); #1;
        end
        if (EX_x_rd_vld) vcount++;
        ID_flush = 1'b1;
        @(posedge clk); #1;
        ID_flush = 1'b0;
        if (EX_x_rd_vld) vcount++;
        check("flush_md_rdy_t11", {31'd0, EX_rdy}, 32'd1);
        check("flush_md_busy_t11", {31'd0, EX_busy}, 32'd0);
        drive(EX_OP_ADD, 5'd4, 1'b1, 1'b0, 32'd0, 32'd2, 32'd3);
        @(posedge clk); #1;
        ID_vld = 1'b0;
        check("flush_add_vld_t12", {31'd0, EX_x_rd_vld}, 32'd1);
        check("flush_add_value", EX_x_rd, 32'd5);
        check("flush_add_rd", {27'd0, EX_rd}, 32'd4);
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (EX_x_rd_vld) vcount++;
        end
        check("flush_md_stray_vld", vcount, 0);

        // Back-to-back: ADD accepted in the same cycle the MUL result is valid.
        wait_rdy("b2b");
        drive(EX_OP_MUL, 5'd1, 1'b1, 1'b0, 32'd0, 32'd6, 32'd7);
        @(posedge clk); #1;
        ID_vld = 1'b0;
        repeat (33) begin @(posedge clk); #1; end
        check("b2b_mul_vld_t34", {31'd0, EX_x_rd_vld}, 32'd1);
        check("b2b_mul_value", EX_x_rd, 32'd42);
        check("b2b_rdy_t34", {31'd0, EX_rdy}, 32'd1);
        drive(EX_OP_ADD, 5'd2, 1'b1, 1'b0, 32'd0, 32'd1, 32'd1);
        @(posedge clk); #1;
        ID_vld = 1'b0;
        check("b2b_add_vld", {31'd0, EX_x_rd_vld}, 32'd1);
        check("b2b_add_value", EX_x_rd, 32'd2);
        check("b2b_add_rd", {27'd0, EX_rd}, 32'd2);

        // Reset mid-CALC abandons the op.
        wait_rdy("rst_md");
        drive(EX_OP_MULHU, 5'd3, 1'b1, 1'b0, 32'd0, 32'd9, 32'd9);
        @(posedge clk); #1;
        ID_vld = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_md_rdy", {31'd0, EX_rdy}, 32'd1);
        check("rst_md_busy", {31'd0, EX_busy}, 32'd0);
        vcount = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (EX_x_rd_vld) vcount++;
        end
        check("rst_md_stray_vld", vcount, 0);
`endif

        // Random ops scored against the model through the expected queue.
        for (int n = 0; n < 60; n++) begin
            op      = 5'($urandom_range(0, 31));
            rd      = 5'($urandom_range(0, 31));
            wen     = 1'($urandom_range(0, 3) != 0);
            use_imm = 1'($urandom_range(0, 1));
            rs1     = pick_operand();
            rs2     = pick_operand();
            imm     = pick_operand();
            b       = use_imm ? imm : rs2;
            model(op, rs1, b, lat, val);
            if (lat > 0 && wen && rd != 0) exp_q.push_back({rd, val});
            wait_rdy("rand");
            drive(op, rd, wen, use_imm, imm, rs1, rs2);
            @(posedge clk); #1;
            ID_vld = 1'b0;
            vcount = 0;
            for (int k = 1; k <= ((lat == 0) ? 2 : lat + 1); k++) begin
                if (k > 1) begin @(posedge clk); #1; end
                if (EX_x_rd_vld) begin
                    if (exp_q.size() == 0) begin
                        check("rand_unexpected_vld", {27'd0, EX_rd}, 32'hFFFF_FFFF);
                    end else begin
                        got_e = exp_q.pop_front();
                        check("rand_rd", {27'd0, EX_rd}, {27'd0, got_e[36:32]});
                        check("rand_value", EX_x_rd, got_e[31:0]);
                    end
                end
                if (EX_illegal) vcount++;
            end
            check("rand_illegal_count", vcount, (lat == 0) ? 1 : 0);
            check("rand_sb_drain", exp_q.size(), 0);
            exp_q.delete();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
